// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction-memory handshake, decode feedback and IF/ID outputs.
// The master modport belongs to the fetch unit; the slave modport belongs to memory/decode.
interface instr_fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  modport master (
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted,
    input  ihit, imemload, stall, redirect, redirect_pc, halt
  );

  modport slave (
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted,
    output ihit, imemload, stall, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, iREN/ihit handshake, IF/ID register, and a one-entry skid
// that parks a word fetched during a stall so it is delivered without a refetch.
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input logic                 CLK,
  input logic                 nRST,
  instr_fetch_unit_if.master  fu
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } fetch_word_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_word_t ifid_q, ifid_d;
  logic        ifid_valid_q, ifid_valid_d;
  fetch_word_t skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;

  logic        ren;
  logic        fetched;
  fetch_word_t fetch_word;

  // A parked skid word suppresses the request until decode drains it.
  assign ren        = (state_q == RUN) && !skid_valid_q;
  assign fetched    = ren && fu.ihit;
  assign fetch_word = '{instr: fu.imemload, npc: pc_q + PC_STEP};

  assign fu.imemREN    = ren;
  assign fu.imemaddr   = pc_q;
  assign fu.ifid_instr = ifid_q.instr;
  assign fu.ifid_npc   = ifid_q.npc;
  assign fu.ifid_valid = ifid_valid_q;
  assign fu.halted     = (state_q == HALTED);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (state_q == RUN) begin
      if (fu.halt) begin
        state_d      = HALTED;
        ifid_valid_d = 1'b0;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (fu.redirect) begin
        // Squash wins over any hit this cycle; IF/ID payload holds even under stall.
        pc_d         = fu.redirect_pc & ~32'd3;
        ifid_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (!fu.stall) begin
        if (skid_valid_q) begin
          ifid_d       = skid_q;
          ifid_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (fetched) begin
          ifid_d       = fetch_word;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_STEP;
        end else begin
          ifid_valid_d = 1'b0;
        end
      end else if (fetched) begin
        skid_d       = fetch_word;
        skid_valid_d = 1'b1;
        pc_d         = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= RUN;
      pc_q         <= PC_INIT;
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch stream.
module tb_instr_fetch_unit;

  logic CLK;
  logic nRST;
  int   n_pass;
  int   n_total;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.PC_INIT(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .fu  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Combinational zero-latency memory; latency is modelled by ihit.
  assign bus.imemload = mem_word(bus.imemaddr);

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.ihit        = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({bus.imemREN, bus.imemaddr, bus.halted} !== {1'b1, 32'h0, 1'b0}) begin
      $display("FAIL reset_ctl got ren=%b addr=%h halted=%b exp ren=1 addr=0 halted=0",
               bus.imemREN, bus.imemaddr, bus.halted);
    end else n_pass++;
    n_total++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc} !== {1'b0, 64'h0}) begin
      $display("FAIL reset_ifid got v=%b i=%h n=%h exp all zero",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_npc);
    end else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (bus.imemaddr !== 32'(4 * k)) begin
        $display("FAIL seq_addr%0d got %h exp %h", k, bus.imemaddr, 32'(4 * k));
      end else n_pass++;
      cyc();
      n_total++;
      if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc} !==
          {1'b1, mem_word(32'(4 * k)), 32'(4 * k + 4)}) begin
        $display("FAIL seq_ifid%0d got v=%b i=%h n=%h exp v=1 i=%h n=%h", k,
                 bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, mem_word(32'(4 * k)), 32'(4 * k + 4));
      end else n_pass++;
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    cyc();
    cyc();
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_total++;
      if ({bus.imemREN, bus.imemaddr} !== {1'b0, 32'd12}) begin
        $display("FAIL stall_req%0d got ren=%b addr=%h exp ren=0 addr=0000000c",
                 k, bus.imemREN, bus.imemaddr);
      end else n_pass++;
      n_total++;
      if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc} !== {1'b1, mem_word(32'd4), 32'd8}) begin
        $display("FAIL stall_hold%0d got v=%b i=%h n=%h exp v=1 i=%h n=8", k,
                 bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, mem_word(32'd4));
      end else n_pass++;
    end
    bus.stall = 1'b0;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, bus.imemREN, bus.imemaddr} !==
        {1'b1, mem_word(32'd8), 32'd12, 1'b1, 32'd12}) begin
      $display("FAIL skid_drain got v=%b i=%h n=%h ren=%b addr=%h exp v=1 i=%h n=c ren=1 addr=c",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, bus.imemREN, bus.imemaddr, mem_word(32'd8));
    end else n_pass++;
    cyc();
    n_total++;
    if ({bus.ifid_instr, bus.ifid_npc} !== {mem_word(32'd12), 32'd16}) begin
      $display("FAIL skid_next got i=%h n=%h exp i=%h n=10", bus.ifid_instr, bus.ifid_npc, mem_word(32'd12));
    end else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.imemaddr} !== {1'b0, 32'h40}) begin
      $display("FAIL redir_squash got v=%b addr=%h exp v=0 addr=40", bus.ifid_valid, bus.imemaddr);
    end else n_pass++;
    bus.redirect = 1'b0;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc} !== {1'b1, mem_word(32'h40), 32'h44}) begin
      $display("FAIL redir_target got v=%b i=%h n=%h exp v=1 i=%h n=44",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, mem_word(32'h40));
    end else n_pass++;
  endtask

  task automatic test_redirect_skid();
    do_reset();
    cyc();
    bus.stall = 1'b1;
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.imemREN, bus.imemaddr, bus.ifid_instr} !==
        {1'b0, 1'b1, 32'h100, mem_word(32'h0)}) begin
      $display("FAIL rskid_squash got v=%b ren=%b addr=%h i=%h exp v=0 ren=1 addr=100 i=%h",
               bus.ifid_valid, bus.imemREN, bus.imemaddr, bus.ifid_instr, mem_word(32'h0));
    end else n_pass++;
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc} !== {1'b1, mem_word(32'h100), 32'h104}) begin
      $display("FAIL rskid_target got v=%b i=%h n=%h exp v=1 i=%h n=104",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, mem_word(32'h100));
    end else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    cyc();
    bus.halt        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    cyc();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({bus.halted, bus.imemREN, bus.imemaddr, bus.ifid_valid} !== {1'b1, 1'b0, 32'h4, 1'b0}) begin
        $display("FAIL halt%0d got halted=%b ren=%b addr=%h v=%b exp halted=1 ren=0 addr=4 v=0",
                 k, bus.halted, bus.imemREN, bus.imemaddr, bus.ifid_valid);
      end else n_pass++;
      bus.halt        = 1'($urandom_range(0, 1));
      bus.redirect    = 1'($urandom_range(0, 1));
      bus.stall       = 1'($urandom_range(0, 1));
      bus.ihit        = 1'b1;
      bus.redirect_pc = $urandom;
      cyc();
    end
    nRST = 1'b0;
    #1;
    n_total++;
    if ({bus.halted, bus.imemaddr, bus.imemREN} !== {1'b0, 32'h0, 1'b1}) begin
      $display("FAIL halt_reset got halted=%b addr=%h ren=%b exp halted=0 addr=0 ren=1",
               bus.halted, bus.imemaddr, bus.imemREN);
    end else n_pass++;
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    bus.ihit     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_total++;
      if ({bus.ifid_valid, bus.imemaddr, bus.imemREN} !== {1'b0, 32'hFFFF_FFFC, 1'b1}) begin
        $display("FAIL wrap_wait%0d got v=%b addr=%h ren=%b exp v=0 addr=fffffffc ren=1",
                 k, bus.ifid_valid, bus.imemaddr, bus.imemREN);
      end else n_pass++;
    end
    bus.ihit = 1'b1;
    cyc();
    n_total++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, bus.imemaddr} !==
        {1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
      $display("FAIL wrap_hit got v=%b i=%h n=%h addr=%h exp v=1 i=%h n=0 addr=0",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, bus.imemaddr, mem_word(32'hFFFF_FFFC));
    end else n_pass++;
  endtask

  // Reference model: the fetch stream as a PC, a pending-word queue (at most one deep)
  // and the word currently presented to decode.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } word_t;

  task automatic test_random();
    logic [31:0] m_pc;
    logic        m_halted;
    word_t       m_ifid;
    logic        m_valid;
    word_t       pend[$];
    int          hcnt;
    logic        m_ren;
    do_reset();
    m_pc = 32'h0; m_halted = 1'b0; m_ifid = '{32'h0, 32'h0}; m_valid = 1'b0; hcnt = 0;
    pend.delete();
    for (int c = 0; c < 600; c++) begin
      m_ren = !m_halted && (pend.size() == 0);
      n_total++;
      if ({bus.imemREN, bus.imemaddr, bus.halted} !== {m_ren, m_pc, m_halted}) begin
        $display("FAIL rnd_ctl c%0d got ren=%b addr=%h halted=%b exp ren=%b addr=%h halted=%b",
                 c, bus.imemREN, bus.imemaddr, bus.halted, m_ren, m_pc, m_halted);
      end else n_pass++;
      n_total++;
      if (bus.ifid_valid !== m_valid ||
          (m_valid && {bus.ifid_instr, bus.ifid_npc} !== {m_ifid.instr, m_ifid.npc})) begin
        $display("FAIL rnd_ifid c%0d got v=%b i=%h n=%h exp v=%b i=%h n=%h", c,
                 bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, m_valid, m_ifid.instr, m_ifid.npc);
      end else n_pass++;
      if (m_halted) hcnt++;
      if (hcnt > 3) begin
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        m_pc = 32'h0; m_halted = 1'b0; m_valid = 1'b0; hcnt = 0;
        pend.delete();
        m_ren = 1'b1;
      end
      bus.stall       = ($urandom_range(0, 99) < 30);
      bus.redirect    = ($urandom_range(0, 99) < 8);
      bus.halt        = ($urandom_range(0, 99) < 2);
      bus.ihit        = ($urandom_range(0, 99) < 65);
      bus.redirect_pc = $urandom;
      if (m_halted) begin
        // nothing changes until reset
      end else if (bus.halt) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
        pend.delete();
      end else if (bus.redirect) begin
        m_pc    = bus.redirect_pc & ~32'd3;
        m_valid = 1'b0;
        pend.delete();
      end else if (!bus.stall) begin
        if (pend.size() != 0) begin
          m_ifid  = pend.pop_front();
          m_valid = 1'b1;
        end else if (m_ren && bus.ihit) begin
          m_ifid  = '{mem_word(m_pc), m_pc + 32'd4};
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end else begin
          m_valid = 1'b0;
        end
      end else if (m_ren && bus.ihit) begin
        pend.push_back('{mem_word(m_pc), m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
      cyc();
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nRST    = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect();
    test_redirect_skid();
    test_halt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
